// File: rtl/adc_serial_emulator_if.sv
// ---------------------------------------------------------------------------
// adc_serial_emulator_if
//   Parallel sample handshake between the AXI-side sample source and the
//   ADC serial emulator.
//
//   S_DATA   sample to transmit (source -> emulator)
//   S_VALID  S_DATA is valid   (source -> emulator)
//   S_READY  emulator can take a sample; transfer when S_VALID && S_READY
//
//   modport master : sample source
//   modport slave  : emulator
// ---------------------------------------------------------------------------
interface adc_serial_emulator_if #(
    parameter int DATA_WIDTH = 14
);
    logic [DATA_WIDTH-1:0] S_DATA;
    logic                  S_VALID;
    logic                  S_READY;

    modport master (
        output S_DATA,
        output S_VALID,
        input  S_READY
    );

    modport slave (
        input  S_DATA,
        input  S_VALID,
        output S_READY
    );
endinterface

// File: rtl/adc_serial_emulator.sv
// ---------------------------------------------------------------------------
// adc_serial_emulator
//   Emulates the quad-ADC serial front end: generates DATA_CLK, FRAME_CLK and
//   two DDR data lanes from 14-bit samples taken on a valid/ready handshake.
//   One sample is sent per frame as W = {sample, 2'b00}, MSB first, lane A
//   carrying the even-offset bits W[15-2k] and lane B W[14-2k] in slot k.
//
//   AXI_CLK        sole clock
//   RESET          synchronous, active-high reset
//   ENABLE         run/stop; a stop takes effect at the end of a frame
//   s_axis         sample handshake (S_DATA / S_VALID / S_READY), slave side
//   ADC_DATA_CLK   bit clock, edges at the centre of each bit slot
//   ADC_FRAME_CLK  high for slots 0-3, low for slots 4-7
//   ADC_LANE_A/B   serial data lanes
//   UNDERRUN       sticky: a frame started without a fresh sample
//   UNDERRUN_CLR   clears UNDERRUN (a simultaneous set wins)
//   FRAME_COUNT    frames started, wraps at 16 bits
// ---------------------------------------------------------------------------
module adc_serial_emulator #(
    parameter int CLKS_PER_BIT = 2,
    parameter int DATA_WIDTH   = 14
) (
    input  logic                        AXI_CLK,
    input  logic                        RESET,
    input  logic                        ENABLE,
    adc_serial_emulator_if.slave        s_axis,
    output logic                        ADC_DATA_CLK,
    output logic                        ADC_FRAME_CLK,
    output logic                        ADC_LANE_A,
    output logic                        ADC_LANE_B,
    output logic                        UNDERRUN,
    input  logic                        UNDERRUN_CLR,
    output logic [15:0]                 FRAME_COUNT
);

    localparam int WORD_W  = DATA_WIDTH + 2;
    localparam int TIMER_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(CLKS_PER_BIT / 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_reg, state_next;
    logic [TIMER_W-1:0]      timer_reg;
    logic [2:0]              slot_reg;
    logic [WORD_W-1:0]       shift_reg;
    logic [DATA_WIDTH-1:0]   word_reg;      // last sample loaded, for retransmit
    logic [DATA_WIDTH-1:0]   hold_reg;
    logic                    hold_valid_reg;
    logic                    underrun_reg;
    logic [15:0]             frame_count_reg;

    logic                    frame_load;
    logic                    slot_last;
    logic                    frame_end;
    logic                    s_ready;
    logic                    accept;

    assign slot_last = (timer_reg == TIMER_LAST);
    assign frame_end = (state_reg == RUN) && slot_last && (slot_reg == 3'd7);

    // Hold register frees up in the same cycle the frame boundary drains it,
    // so a continuous source sees exactly one accept per frame.
    assign s_ready        = !RESET && (!hold_valid_reg || frame_load);
    assign s_axis.S_READY = s_ready;
    assign accept         = s_axis.S_VALID && s_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. Starting from IDLE loads the first frame in the same
    // cycle; in RUN a new frame only starts if ENABLE is still high at the
    // end of slot 7, otherwise the emulator parks in IDLE without loading.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        frame_load = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ENABLE) begin
                    state_next = RUN;
                    frame_load = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (ENABLE) begin
                        frame_load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: bit timer, slot index, shift word, holding register, status
    // -----------------------------------------------------------------------
    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            timer_reg       <= '0;
            slot_reg        <= '0;
            shift_reg       <= '0;
            word_reg        <= '0;
            hold_reg        <= '0;
            hold_valid_reg  <= 1'b0;
            underrun_reg    <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            if (frame_load) begin
                timer_reg <= '0;
                slot_reg  <= '0;
            end else if (state_reg == RUN) begin
                if (slot_last) begin
                    timer_reg <= '0;
                    slot_reg  <= slot_reg + 3'd1;   // 7 wraps to 0
                end else begin
                    timer_reg <= timer_reg + 1'b1;
                end
            end else begin
                timer_reg <= '0;
                slot_reg  <= '0;
            end

            if (frame_load) begin
                if (hold_valid_reg) begin
                    shift_reg <= {hold_reg, 2'b00};
                    word_reg  <= hold_reg;
                end else begin
                    shift_reg <= {word_reg, 2'b00};
                end
            end else if ((state_reg == RUN) && slot_last) begin
                shift_reg <= shift_reg << 2;
            end

            if (accept) begin
                hold_reg <= s_axis.S_DATA;
            end

            // Refill wins over drain when both happen in one cycle.
            if (accept) begin
                hold_valid_reg <= 1'b1;
            end else if (frame_load) begin
                hold_valid_reg <= 1'b0;
            end

            if (frame_load && !hold_valid_reg) begin
                underrun_reg <= 1'b1;
            end else if (UNDERRUN_CLR) begin
                underrun_reg <= 1'b0;
            end

            if (frame_load) begin
                frame_count_reg <= frame_count_reg + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. DATA_CLK is slot parity XOR "past mid-slot", which puts
    // its edges at timer == CLKS_PER_BIT/2 and keeps it low in the first half
    // of slot 0. Downstream logic samples these in the AXI_CLK domain.
    // -----------------------------------------------------------------------
    always_comb begin
        ADC_LANE_A    = 1'b0;
        ADC_LANE_B    = 1'b0;
        ADC_FRAME_CLK = 1'b0;
        ADC_DATA_CLK  = 1'b0;
        if (state_reg == RUN) begin
            ADC_LANE_A    = shift_reg[WORD_W-1];
            ADC_LANE_B    = shift_reg[WORD_W-2];
            ADC_FRAME_CLK = ~slot_reg[2];
            ADC_DATA_CLK  = slot_reg[0] ^ (timer_reg >= TIMER_HALF);
        end
        UNDERRUN    = underrun_reg;
        FRAME_COUNT = frame_count_reg;
    end

endmodule
